// File: rtl/storage_pkg.sv
// storage_pkg: shared SRAM geometry and the response tag carried down the
// arbiter's read pipeline.
package storage_pkg;

    localparam int ROW_W  = 8;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int BLK_W  = 8;

    typedef struct packed {
        logic             id;
        logic [BLK_W-1:0] block;
        logic             err;
        logic             is_write;
    } rsp_tag_t;

endpackage

// File: rtl/storage_rr_arb.sv
// storage_rr_arb: two-way round-robin grant; the pointer moves to the loser
// only after a contested grant is taken.
module storage_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic ptr;

    always_comb grant = (&req) ? {ptr, ~ptr} : req;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            ptr <= 1'b0;
        else if (update && &req)
            ptr <= grant[0];

endmodule

// File: rtl/storage_arbiter.sv
// storage_arbiter: two requesters share BLOCKS 32x256 SRAMs, fixed 3-edge response.
// Define STORAGE_ARB_RANGE_CHECK_EN to flag out-of-range addresses instead of aliasing.
module storage_arbiter
    import storage_pkg::*;
#(
    parameter int BLOCKS = 2,
    parameter int ADDR_W = 10
) (
    input  logic                       mgmt_clk,
    input  logic                       mgmt_rst,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_we,
    input  logic [2*MASK_W-1:0]        req_wmask,
    input  logic [2*ADDR_W-1:0]        req_addr,
    input  logic [2*DATA_W-1:0]        req_wdata,
    output logic [1:0]                 rsp_valid,
    output logic                       rsp_err,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [BLOCKS-1:0]          mgmt_ena,
    output logic [BLOCKS-1:0]          mgmt_wen,
    output logic [MASK_W*BLOCKS-1:0]   mgmt_wen_mask,
    output logic [ROW_W-1:0]           mgmt_addr,
    output logic [DATA_W-1:0]          mgmt_wdata,
    input  logic [DATA_W*BLOCKS-1:0]   mgmt_rdata
);

    localparam int SEL_W = BLOCKS > 1 ? $clog2(BLOCKS) : 1;
    localparam int HI    = ROW_W + $clog2(BLOCKS);
    localparam int MW    = MASK_W * BLOCKS;

    logic [1:0]          grant;
    logic                id, we, err, go;
    logic [ADDR_W-1:0]   addr;
    logic [SEL_W-1:0]    blk;
    logic [MASK_W-1:0]   wmask;
    logic [DATA_W-1:0]   wdata;
    logic [BLOCKS-1:0]   ena_n, wen_n;
    logic [MW-1:0]       mask_n;
    logic [ROW_W-1:0]    addr_n;
    logic [DATA_W-1:0]   wdata_n;
    rsp_tag_t            tag_n, s1, s2;
    logic                s1_v, s2_v;

    storage_rr_arb u_arb (
        .clk    (mgmt_clk),
        .rst    (mgmt_rst),
        .req    (req_valid),
        .update (|grant),
        .grant  (grant)
    );

    assign req_ready = grant;

    always_comb begin
        id    = grant[1];
        addr  = id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        we    = id ? req_we[1] : req_we[0];
        wmask = id ? req_wmask[2*MASK_W-1:MASK_W] : req_wmask[MASK_W-1:0];
        wdata = id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        blk   = BLOCKS > 1 ? addr[ROW_W +: SEL_W] : '0;
    end

`ifdef STORAGE_ARB_RANGE_CHECK_EN
    assign err = (|(addr >> HI)) || (int'(blk) >= BLOCKS);
`else
    logic unused_hi;
    assign err       = 1'b0;
    assign unused_hi = ^(addr >> HI);
`endif

    // An erroring command still occupies a slot but leaves the SRAMs idle.
    always_comb begin
        go      = |grant && !err;
        ena_n   = ~(BLOCKS'(go) << blk);
        wen_n   = ~(BLOCKS'(go && we) << blk);
        mask_n  = MW'({MASK_W{go && we}} & wmask) << (MASK_W * int'(blk));
        addr_n  = go ? addr[ROW_W-1:0] : '0;
        wdata_n = (go && we) ? wdata : '0;
        tag_n   = '{id: id, block: BLK_W'(blk), err: err, is_write: we};
    end

    always_ff @(posedge mgmt_clk or posedge mgmt_rst)
        if (mgmt_rst) begin
            mgmt_ena      <= '1;
            mgmt_wen      <= '1;
            mgmt_wen_mask <= '0;
            mgmt_addr     <= '0;
            mgmt_wdata    <= '0;
            s1_v          <= 1'b0;
            s1            <= '0;
            s2_v          <= 1'b0;
            s2            <= '0;
            rsp_valid     <= '0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= '0;
        end else begin
            mgmt_ena      <= ena_n;
            mgmt_wen      <= wen_n;
            mgmt_wen_mask <= mask_n;
            mgmt_addr     <= addr_n;
            mgmt_wdata    <= wdata_n;
            s1_v          <= |grant;
            s1            <= tag_n;
            s2_v          <= s1_v;
            s2            <= s1;
            rsp_valid     <= s2_v ? (2'b01 << s2.id) : 2'b00;
            rsp_err       <= s2_v && s2.err;
            rsp_rdata     <= (s2_v && !s2.err && !s2.is_write) ? mgmt_rdata[DATA_W*s2.block +: DATA_W] : '0;
        end

endmodule

// File: tb/tb_storage_arbiter.sv
// tb_storage_arbiter: directed and random traffic against a word-level memory
// model and a due-cycle response scoreboard; SRAM blocks modelled behaviourally.
module tb_storage_arbiter;

    localparam int BLOCKS = 2;
    localparam int ADDR_W = 10;

    logic        mgmt_clk = 1'b0;
    logic        mgmt_rst = 1'b1;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [7:0]  req_wmask;
    logic [19:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  mgmt_ena, mgmt_wen;
    logic [7:0]  mgmt_wen_mask;
    logic [7:0]  mgmt_addr;
    logic [31:0] mgmt_wdata;
    logic [63:0] mgmt_rdata;

    storage_arbiter #(.BLOCKS(BLOCKS), .ADDR_W(ADDR_W)) dut (
        .mgmt_clk(mgmt_clk), .mgmt_rst(mgmt_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mgmt_ena(mgmt_ena), .mgmt_wen(mgmt_wen), .mgmt_wen_mask(mgmt_wen_mask),
        .mgmt_addr(mgmt_addr), .mgmt_wdata(mgmt_wdata), .mgmt_rdata(mgmt_rdata)
    );

    always #5 mgmt_clk = ~mgmt_clk;

    // Behavioural SRAM blocks: active-low select/write, byte mask, registered read.
    logic        mem_clr = 1'b1;
    logic [31:0] sram [BLOCKS][256];
    always @(posedge mgmt_clk) begin
        if (mem_clr) begin
            for (int b = 0; b < BLOCKS; b++)
                for (int r = 0; r < 256; r++)
                    sram[b][r] <= '0;
        end else begin
            for (int b = 0; b < BLOCKS; b++)
                if (!mgmt_ena[b]) begin
                    if (!mgmt_wen[b])
                        for (int k = 0; k < 4; k++)
                            if (mgmt_wen_mask[4*b+k])
                                sram[b][mgmt_addr][8*k +: 8] <= mgmt_wdata[8*k +: 8];
                    mgmt_rdata[32*b +: 32] <= sram[b][mgmt_addr];
                end
        end
    end

    typedef struct {
        int          due;
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [512];
    logic        ptr = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  exp_ena, exp_wen;
    logic [7:0]  exp_mask, exp_addr;
    logic [31:0] exp_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [7:0] m,
                        input logic [19:0] a, input logic [63:0] wd);
        int          w;
        logic [9:0]  sa;
        logic        e;
        logic [1:0]  g;
        logic [31:0] d, cw;
        exp_t        r;
        req_valid = v;
        req_we    = we;
        req_wmask = m;
        req_addr  = a;
        req_wdata = wd;
        #1;
        g = 2'b00;
        if (v == 2'b11) begin
            w   = int'(ptr);
            ptr = ~ptr;
        end else
            w = int'(v[1]);
        if (v != 2'b00) g = 2'(1 << w);
        chk("ready", 64'(req_ready), 64'(g));
        exp_ena = '1; exp_wen = '1; exp_mask = '0; exp_addr = '0; exp_wdata = '0;
        if (v != 2'b00) begin
            sa = (w == 1) ? a[19:10] : a[9:0];
`ifdef STORAGE_ARB_RANGE_CHECK_EN
            e = sa[9];
`else
            e = 1'b0;
`endif
            d = '0;
            if (!e) begin
                exp_ena[sa[8]] = 1'b0;
                exp_addr       = sa[7:0];
                if (we[w]) begin
                    cw                    = wd[32*w +: 32];
                    exp_wen[sa[8]]        = 1'b0;
                    exp_mask[4*sa[8] +: 4] = m[4*w +: 4];
                    exp_wdata             = cw;
                    for (int k = 0; k < 4; k++)
                        if (m[4*w+k]) ref_mem[sa[8:0]][8*k +: 8] = cw[8*k +: 8];
                end else
                    d = ref_mem[sa[8:0]];
            end
            exp_q.push_back('{due: cyc + 3, id: g, data: d, err: e});
        end
        @(posedge mgmt_clk);
        cyc++;
        #1;
        chk("ena", 64'(mgmt_ena), 64'(exp_ena));
        chk("wen", 64'(mgmt_wen), 64'(exp_wen));
        chk("mask", 64'(mgmt_wen_mask), 64'(exp_mask));
        chk("addr", 64'(mgmt_addr), 64'(exp_addr));
        chk("wdata", 64'(mgmt_wdata), 64'(exp_wdata));
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(r.id));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(r.data));
            chk("rsp_err", 64'(rsp_err), 64'(r.err));
        end else
            chk("rsp_idle", 64'(rsp_valid), 64'(0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 8'h00, 20'h0, 64'h0);
    endtask

    initial begin
        req_valid = '0; req_we = '0; req_wmask = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        repeat (2) @(posedge mgmt_clk);
        #1;
        chk("rst_ena", 64'(mgmt_ena), 64'(2'b11));
        chk("rst_wen", 64'(mgmt_wen), 64'(2'b11));
        chk("rst_mask", 64'(mgmt_wen_mask), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        mem_clr  = 1'b0;
        mgmt_rst = 1'b0;

        // write then read back 0x105 (block 1, row 5)
        step(2'b01, 2'b01, 8'h0F, 20'h00105, 64'hDEADBEEF);
        chk("ena_wr105", 64'(mgmt_ena), 64'(2'b01));
        step(2'b01, 2'b00, 8'h00, 20'h00105, 64'h0);
        idle(2);
        chk("rdata_105", 64'(rsp_rdata), 64'h00000000DEADBEEF);
        idle(2);

        // byte-masked overwrite
        step(2'b01, 2'b01, 8'h0F, 20'h00033, 64'h11223344);
        step(2'b01, 2'b01, 8'h02, 20'h00033, 64'hAAAAAAAA);
        step(2'b01, 2'b00, 8'h00, 20'h00033, 64'h0);
        idle(2);
        chk("rdata_mask", 64'(rsp_rdata), 64'h000000001122AA44);
        idle(2);

        // contention: grants alternate 0,1,0,1; zero-mask write still responds
        step(2'b11, 2'b00, 8'h00, {10'h033, 10'h105}, 64'h0);
        step(2'b11, 2'b10, 8'h00, {10'h0A0, 10'h105}, 64'h12345678_0);
        step(2'b11, 2'b01, 8'hF5, {10'h033, 10'h1FF}, 64'h0_CAFEF00D);
        step(2'b11, 2'b00, 8'h00, {10'h1FF, 10'h105}, 64'h0);
        idle(4);

        // upper address bit set
        step(2'b10, 2'b00, 8'h00, {10'h200, 10'h000}, 64'h0);
        idle(4);

        // reset one cycle after an accept, with the pointer left at 1
        step(2'b11, 2'b00, 8'h00, {10'h033, 10'h105}, 64'h0);
        mgmt_rst = 1'b1;
        #1;
        chk("midrst_ena", 64'(mgmt_ena), 64'(2'b11));
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        exp_q.delete();
        ptr = 1'b0;
        repeat (2) @(posedge mgmt_clk);
        #1;
        chk("midrst_hold_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_hold_rdata", 64'(rsp_rdata), 64'(0));
        mgmt_rst = 1'b0;
        step(2'b11, 2'b00, 8'h00, {10'h033, 10'h105}, 64'h0);
        idle(5);

        for (int i = 0; i < 400; i++)
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom),
                 20'($urandom), {$urandom, $urandom});
        idle(5);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
